// File: rtl/match_engine.sv
// Turn-based pair-matching engine for the memory game. It reveals clicked cards, compares their colours,
// marks or re-hides each pair and keeps per-player scores. Define MG_TURN_TIMEOUT_EN to add a per-turn pass timer.
module match_engine #(
    parameter int NUM_PLAYERS  = 2,
    parameter int ADDR_W       = 6,
    parameter int COLOR_W      = 4,
    parameter int SCORE_W      = 6,
    parameter int HIDE_DELAY   = 65000000,
    parameter int TURN_TIMEOUT = 650000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W:0]                num_of_cards,
    input  logic                           card_pressed,
    input  logic [ADDR_W-1:0]              card_clicked_address,
    input  logic [COLOR_W-1:0]             card_clicked_color,
    output logic                           wait_for_click_en,
    output logic                           write_card_en,
    output logic [ADDR_W-1:0]              write_card_address,
    output logic [1:0]                     write_card_state,
    output logic [2:0]                     current_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [ADDR_W-1:0]              pairs_found,
    output logic [15:0]                    moves,
    output logic                           game_over
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_WAIT_FIRST  = 4'd1,
        S_WAIT_SECOND = 4'd2,
        S_COMPARE     = 4'd3,
        S_MARK_A      = 4'd4,
        S_MARK_B      = 4'd5,
        S_SHOW_DELAY  = 4'd6,
        S_HIDE_A      = 4'd7,
        S_HIDE_B      = 4'd8,
        S_DONE        = 4'd9
    } state_t;

    localparam logic [1:0]        CARD_HIDDEN   = 2'd0;
    localparam logic [1:0]        CARD_REVEALED = 2'd1;
    localparam logic [1:0]        CARD_MATCHED  = 2'd2;
    localparam int                DLY_W         = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;
    localparam logic [DLY_W-1:0]  DLY_LAST      = DLY_W'(HIDE_DELAY - 1);
    localparam logic [2:0]        LAST_PLAYER   = 3'(NUM_PLAYERS - 1);
    localparam logic [ADDR_W:0]   MIN_CARDS     = (ADDR_W + 1)'(2);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || HIDE_DELAY < 1 || TURN_TIMEOUT < 1) begin : g_bad_params
        $error("match_engine: parameter out of legal range");
    end

    function automatic logic [2:0] next_player(input logic [2:0] p);
        if (p >= LAST_PLAYER) begin
            return 3'd0;
        end else begin
            return p + 3'd1;
        end
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == {SCORE_W{1'b1}}) begin
            return v;
        end else begin
            return v + SCORE_W'(1);
        end
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_WAIT_FIRST) || (s == S_WAIT_SECOND);
    endfunction

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              slot_a_addr_q, slot_a_addr_d, slot_b_addr_q, slot_b_addr_d;
    logic [COLOR_W-1:0]             slot_a_color_q, slot_a_color_d, slot_b_color_q, slot_b_color_d;
    logic [ADDR_W-1:0]              total_pairs_q, total_pairs_d;
    logic [DLY_W-1:0]               delay_cnt_q, delay_cnt_d;
    logic                           write_en_q, write_en_d;
    logic [ADDR_W-1:0]              write_addr_q, write_addr_d;
    logic [1:0]                     write_state_q, write_state_d;
    logic                           wait_en_q, wait_en_d;
    logic                           game_over_q, game_over_d;
    logic [2:0]                     player_q, player_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [ADDR_W-1:0]              pairs_q, pairs_d;
    logic [15:0]                    moves_q, moves_d;

    logic start_ok_s, click_first_s, click_second_s, colors_eq_s, last_pair_s, timeout_s;

    assign start_ok_s     = start && (num_of_cards >= MIN_CARDS) &&
                            ((state_q == S_IDLE) || (state_q == S_DONE));
    assign click_first_s  = card_pressed && (state_q == S_WAIT_FIRST);
    assign click_second_s = card_pressed && (state_q == S_WAIT_SECOND) &&
                            (card_clicked_address != slot_a_addr_q);
    assign colors_eq_s    = (slot_a_color_q == slot_b_color_q);
    assign last_pair_s    = ((pairs_q + ADDR_W'(1)) == total_pairs_q);

`ifdef MG_TURN_TIMEOUT_EN
    localparam int               TO_W    = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TURN_TIMEOUT - 1);

    logic [TO_W-1:0] turn_cnt_q, turn_cnt_d;

    assign timeout_s = is_wait(state_q) && (turn_cnt_q == TO_LAST) && !click_first_s && !click_second_s;

    // Turn timer: restarts whenever the wait state changes (click accepted) or the turn passes.
    always_comb begin
        turn_cnt_d = '0;
        if (is_wait(state_d) && (state_d == state_q) && !timeout_s) begin
            turn_cnt_d = turn_cnt_q + TO_W'(1);
        end else begin
            turn_cnt_d = '0;
        end
    end

    // Turn timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt_q <= '0;
        end else begin
            turn_cnt_q <= turn_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) state_d = S_WAIT_FIRST;
                else            state_d = state_q;
            end
            S_WAIT_FIRST: begin
                if (click_first_s) state_d = S_WAIT_SECOND;
                else               state_d = S_WAIT_FIRST;
            end
            S_WAIT_SECOND: begin
                if (click_second_s) state_d = S_COMPARE;
                else if (timeout_s) state_d = S_WAIT_FIRST;
                else                state_d = S_WAIT_SECOND;
            end
            S_COMPARE:    state_d = colors_eq_s ? S_MARK_A : S_SHOW_DELAY;
            S_MARK_A:     state_d = S_MARK_B;
            S_MARK_B:     state_d = last_pair_s ? S_DONE : S_WAIT_FIRST;
            S_SHOW_DELAY: state_d = (delay_cnt_q == DLY_LAST) ? S_HIDE_A : S_SHOW_DELAY;
            S_HIDE_A:     state_d = S_HIDE_B;
            S_HIDE_B:     state_d = S_WAIT_FIRST;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic; each write is staged one state ahead so it appears with that state.
    always_comb begin
        slot_a_addr_d  = slot_a_addr_q;
        slot_a_color_d = slot_a_color_q;
        slot_b_addr_d  = slot_b_addr_q;
        slot_b_color_d = slot_b_color_q;
        total_pairs_d  = total_pairs_q;
        delay_cnt_d    = delay_cnt_q;
        write_en_d     = 1'b0;
        write_addr_d   = write_addr_q;
        write_state_d  = write_state_q;
        player_d       = player_q;
        scores_d       = scores_q;
        pairs_d        = pairs_q;
        moves_d        = moves_q;
        wait_en_d      = is_wait(state_d);
        game_over_d    = (state_d == S_DONE);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    player_d      = 3'd0;
                    scores_d      = '0;
                    pairs_d       = '0;
                    moves_d       = 16'd0;
                    total_pairs_d = num_of_cards[ADDR_W:1];
                end else begin
                    total_pairs_d = total_pairs_q;
                end
            end
            S_WAIT_FIRST: begin
                if (click_first_s) begin
                    slot_a_addr_d  = card_clicked_address;
                    slot_a_color_d = card_clicked_color;
                    write_en_d     = 1'b1;
                    write_addr_d   = card_clicked_address;
                    write_state_d  = CARD_REVEALED;
                end else if (timeout_s) begin
                    player_d = next_player(player_q);
                end else begin
                    player_d = player_q;
                end
            end
            S_WAIT_SECOND: begin
                if (click_second_s) begin
                    slot_b_addr_d  = card_clicked_address;
                    slot_b_color_d = card_clicked_color;
                    write_en_d     = 1'b1;
                    write_addr_d   = card_clicked_address;
                    write_state_d  = CARD_REVEALED;
                end else if (timeout_s) begin
                    write_en_d    = 1'b1;
                    write_addr_d  = slot_a_addr_q;
                    write_state_d = CARD_HIDDEN;
                    player_d      = next_player(player_q);
                end else begin
                    player_d = player_q;
                end
            end
            S_COMPARE: begin
                moves_d     = moves_q + 16'd1;
                delay_cnt_d = '0;
                if (colors_eq_s) begin
                    write_en_d    = 1'b1;
                    write_addr_d  = slot_a_addr_q;
                    write_state_d = CARD_MATCHED;
                end else begin
                    write_en_d = 1'b0;
                end
            end
            S_MARK_A: begin
                write_en_d    = 1'b1;
                write_addr_d  = slot_b_addr_q;
                write_state_d = CARD_MATCHED;
            end
            S_MARK_B: begin
                pairs_d = pairs_q + ADDR_W'(1);
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (player_q == 3'(p)) begin
                        scores_d[p*SCORE_W +: SCORE_W] = sat_inc(scores_q[p*SCORE_W +: SCORE_W]);
                    end else begin
                        scores_d[p*SCORE_W +: SCORE_W] = scores_q[p*SCORE_W +: SCORE_W];
                    end
                end
            end
            S_SHOW_DELAY: begin
                if (delay_cnt_q == DLY_LAST) begin
                    write_en_d    = 1'b1;
                    write_addr_d  = slot_a_addr_q;
                    write_state_d = CARD_HIDDEN;
                end else begin
                    delay_cnt_d = delay_cnt_q + DLY_W'(1);
                end
            end
            S_HIDE_A: begin
                write_en_d    = 1'b1;
                write_addr_d  = slot_b_addr_q;
                write_state_d = CARD_HIDDEN;
            end
            S_HIDE_B: begin
                player_d = next_player(player_q);
            end
            default: begin
                write_en_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_a_addr_q  <= '0;
            slot_a_color_q <= '0;
            slot_b_addr_q  <= '0;
            slot_b_color_q <= '0;
            total_pairs_q  <= '0;
            delay_cnt_q    <= '0;
            write_en_q     <= 1'b0;
            write_addr_q   <= '0;
            write_state_q  <= 2'd0;
            wait_en_q      <= 1'b0;
            game_over_q    <= 1'b0;
            player_q       <= 3'd0;
            scores_q       <= '0;
            pairs_q        <= '0;
            moves_q        <= 16'd0;
        end else begin
            slot_a_addr_q  <= slot_a_addr_d;
            slot_a_color_q <= slot_a_color_d;
            slot_b_addr_q  <= slot_b_addr_d;
            slot_b_color_q <= slot_b_color_d;
            total_pairs_q  <= total_pairs_d;
            delay_cnt_q    <= delay_cnt_d;
            write_en_q     <= write_en_d;
            write_addr_q   <= write_addr_d;
            write_state_q  <= write_state_d;
            wait_en_q      <= wait_en_d;
            game_over_q    <= game_over_d;
            player_q       <= player_d;
            scores_q       <= scores_d;
            pairs_q        <= pairs_d;
            moves_q        <= moves_d;
        end
    end

    assign wait_for_click_en  = wait_en_q;
    assign write_card_en      = write_en_q;
    assign write_card_address = write_addr_q;
    assign write_card_state   = write_state_q;
    assign current_player     = player_q;
    assign scores             = scores_q;
    assign pairs_found        = pairs_q;
    assign moves              = moves_q;
    assign game_over          = game_over_q;

endmodule

// File: tb/tb_match_engine.sv
// Bench for match_engine: a table of directed turns with exact write timing, then random games
// checked against a card-level model of the game rules.
module tb_match_engine;
    localparam int NP = 2;
    localparam int AW = 6;
    localparam int CW = 4;
    localparam int SW = 3;
    localparam int HD = 10;

    logic             clk = 1'b0;
    logic             rst, start, card_pressed;
    logic [AW:0]      num_of_cards;
    logic [AW-1:0]    card_clicked_address;
    logic [CW-1:0]    card_clicked_color;
    logic             wait_for_click_en, write_card_en, game_over;
    logic [AW-1:0]    write_card_address, pairs_found;
    logic [1:0]       write_card_state;
    logic [2:0]       current_player;
    logic [NP*SW-1:0] scores;
    logic [15:0]      moves;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    match_engine #(.NUM_PLAYERS(NP), .ADDR_W(AW), .COLOR_W(CW), .SCORE_W(SW),
                   .HIDE_DELAY(HD), .TURN_TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .start(start), .num_of_cards(num_of_cards),
        .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
        .card_clicked_color(card_clicked_color), .wait_for_click_en(wait_for_click_en),
        .write_card_en(write_card_en), .write_card_address(write_card_address),
        .write_card_state(write_card_state), .current_player(current_player),
        .scores(scores), .pairs_found(pairs_found), .moves(moves), .game_over(game_over));

    logic [7:0] act_q[$];
    logic [7:0] exp_q[$];

    // Record every write strobe as {address, state}.
    always @(negedge clk) begin
        if (write_card_en) act_q.push_back({write_card_address, write_card_state});
    end

    typedef struct {
        logic [AW-1:0]    a_addr;
        logic [CW-1:0]    a_col;
        logic [AW-1:0]    b_addr;
        logic [CW-1:0]    b_col;
        logic [2:0]       exp_player;
        logic [15:0]      exp_moves;
        logic [AW-1:0]    exp_pairs;
        logic [NP*SW-1:0] exp_scores;
        logic             exp_over;
    } vec_t;

    vec_t vecs[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic click(input logic [AW-1:0] a, input logic [CW-1:0] c);
        card_pressed = 1'b1;
        card_clicked_address = a;
        card_clicked_color = c;
        tick();
        card_pressed = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_of_cards = 7'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_turn_end();
        int n = 0;
        while (!(wait_for_click_en || game_over) && n < 60) begin
            tick();
            n++;
        end
        chk("turn_end_bound", 32'(n < 60), 32'd1);
    endtask

    // Model state for random games
    int col[64];
    bit gone[64];
    int m_score[NP];
    int m_player, m_moves, m_pairs;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, np, i, j, r, tmp, turns;
        bit perfect, want;
        int un[$];
        logic [NP*SW-1:0] es;

        vecs[0] = '{6'd0, 4'd3, 6'd1, 4'd3, 3'd0, 16'd1, 6'd1, 6'b000_001, 1'b0};
        vecs[1] = '{6'd2, 4'd5, 6'd3, 4'd7, 3'd1, 16'd2, 6'd1, 6'b000_001, 1'b0};
        vecs[2] = '{6'd2, 4'd6, 6'd3, 4'd6, 3'd1, 16'd3, 6'd2, 6'b001_001, 1'b1};

        rst = 1'b1; start = 1'b0; card_pressed = 1'b0; num_of_cards = '0;
        card_clicked_address = '0; card_clicked_color = '0;
        tick(); tick();
        chk("reset_flags", {write_card_en, wait_for_click_en, game_over, current_player, pairs_found, scores}, 32'd0);
        chk("reset_moves", moves, 32'd0);
        rst = 1'b0;
        tick();
        do_start(4);
        chk("start_wait_en", wait_for_click_en, 32'd1);
        chk("start_scores", scores, 32'd0);

        for (int v = 0; v < 3; v++) begin
            click(vecs[v].a_addr, vecs[v].a_col);
            chk("reveal_a", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].a_addr, 2'd1});
            tick();
            chk("strobe_one_cycle", write_card_en, 32'd0);
            click(vecs[v].a_addr, vecs[v].b_col);
            chk("same_addr_no_write", write_card_en, 32'd0);
            chk("same_addr_still_wait", wait_for_click_en, 32'd1);
            click(vecs[v].b_addr, vecs[v].b_col);
            chk("reveal_b", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].b_addr, 2'd1});
            tick();
            if (vecs[v].a_col == vecs[v].b_col) begin
                chk("matched_a", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].a_addr, 2'd2});
                tick();
                chk("matched_b", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].b_addr, 2'd2});
            end else begin
                bad = 0;
                for (int k = 1; k <= HD; k++) begin
                    if (write_card_en) bad++;
                    if (k == 3) begin
                        card_pressed = 1'b1;
                        card_clicked_address = vecs[v].b_addr + 6'd1;
                    end
                    tick();
                    card_pressed = 1'b0;
                end
                chk("show_delay_quiet", bad, 32'd0);
                chk("hidden_a", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].a_addr, 2'd0});
                tick();
                chk("hidden_b", {write_card_en, write_card_address, write_card_state}, {1'b1, vecs[v].b_addr, 2'd0});
            end
            tick();
            chk("write_idle", write_card_en, 32'd0);
            chk("player", current_player, vecs[v].exp_player);
            chk("moves", moves, vecs[v].exp_moves);
            chk("pairs", pairs_found, vecs[v].exp_pairs);
            chk("scores", scores, vecs[v].exp_scores);
            chk("game_over", game_over, vecs[v].exp_over);
            chk("wait_en", wait_for_click_en, 32'(!vecs[v].exp_over));
        end

        do_start(1);
        chk("start_too_few_ignored", game_over, 32'd1);
        do_start(4);
        chk("restart_clear", {game_over, wait_for_click_en, current_player, pairs_found, scores}, {1'b0, 1'b1, 3'd0, 6'd0, 6'd0});
        chk("restart_moves", moves, 32'd0);

        click(6'd0, 4'd1);
        click(6'd1, 4'd2);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_flags", {write_card_en, wait_for_click_en, game_over, current_player, pairs_found, scores}, 32'd0);
        chk("rst_mid_moves", moves, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (write_card_en) bad++;
        end
        chk("rst_no_hide_writes", bad, 32'd0);

        for (int g = 0; g < 4; g++) begin
            perfect = (g == 0);
            np = perfect ? 9 : $urandom_range(2, 12);
            for (int k = 0; k < np; k++) begin
                col[2*k] = $urandom_range(0, 15);
                col[2*k+1] = col[2*k];
            end
            for (int k = 2*np-1; k > 0; k--) begin
                r = $urandom_range(0, k);
                tmp = col[k]; col[k] = col[r]; col[r] = tmp;
            end
            for (int k = 0; k < 64; k++) gone[k] = 1'b0;
            for (int p = 0; p < NP; p++) m_score[p] = 0;
            m_player = 0; m_moves = 0; m_pairs = 0; turns = 0;
            do_start(2*np);
            act_q.delete();
            exp_q.delete();
            while (m_pairs < np && turns < 300) begin
                turns++;
                un.delete();
                for (int c = 0; c < 2*np; c++) if (!gone[c]) un.push_back(c);
                i = un[$urandom_range(0, un.size()-1)];
                want = perfect || ($urandom_range(0, 1) == 1);
                j = -1;
                if (want) foreach (un[k]) if (j < 0 && un[k] != i && col[un[k]] == col[i]) j = un[k];
                while (j < 0 || j == i) j = un[$urandom_range(0, un.size()-1)];
                exp_q.push_back({i[5:0], 2'd1});
                exp_q.push_back({j[5:0], 2'd1});
                m_moves = (m_moves + 1) % 65536;
                if (col[i] == col[j]) begin
                    exp_q.push_back({i[5:0], 2'd2});
                    exp_q.push_back({j[5:0], 2'd2});
                    gone[i] = 1'b1; gone[j] = 1'b1;
                    m_pairs++;
                    m_score[m_player] = (m_score[m_player] < 7) ? m_score[m_player] + 1 : 7;
                end else begin
                    exp_q.push_back({i[5:0], 2'd0});
                    exp_q.push_back({j[5:0], 2'd0});
                    m_player = (m_player + 1) % NP;
                end
                click(i[5:0], col[i][3:0]);
                repeat ($urandom_range(0, 2)) tick();
                click(j[5:0], col[j][3:0]);
                wait_turn_end();
                tick();
                chk("rnd_write_count", act_q.size(), exp_q.size());
                for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
                    chk("rnd_write", act_q[k], exp_q[k]);
                act_q.delete();
                exp_q.delete();
                es = {m_score[1][2:0], m_score[0][2:0]};
                chk("rnd_scores", scores, es);
                chk("rnd_player", current_player, m_player);
                chk("rnd_moves", moves, m_moves);
                chk("rnd_pairs", pairs_found, m_pairs);
            end
            chk("rnd_game_over", game_over, 32'd1);
            chk("rnd_wait_off", wait_for_click_en, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
